// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth product accumulator.
// Build option: BOOTH_ACC_SAT_EN selects saturating accumulation (see booth_sat_add).
package booth_pkg;

    // Width of the signed product delivered by the 4x4 Booth multiplier.
    localparam int unsigned PROD_W = 8;

    // Accumulator controller states.
    typedef enum logic [0:0] {
        StAccum = 1'b0,
        StHold  = 1'b1
    } state_e;

    // Sign-extends a product to 32 bits; callers keep the low ACC_W bits.
    function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] prod);
        return {{(32 - PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational ACC_W-bit signed adder with overflow flag.
// Build option: BOOTH_ACC_SAT_EN clamps the result to the signed range on overflow;
// without it the result wraps in two's complement.
module booth_sat_add #(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] SatMax = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] SatMin = {1'b1, {(ACC_W - 1){1'b0}}};

    logic [ACC_W-1:0] raw;

    // Raw sum plus overflow: operands agree in sign but the result does not.
    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    end

`ifdef BOOTH_ACC_SAT_EN
    // Clamp toward the operands' shared sign when the sum escapes the range.
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[ACC_W-1] ? SatMin : SatMax;
        end
    end
`else
    // Plain two's-complement wrap.
    always_comb begin
        sum = raw;
    end

    logic unused_sat_consts;
    assign unused_sat_consts = ^{SatMax, SatMin};
`endif

endmodule

// File: rtl/booth_product_accum.sv
// Sums batches of COUNT signed Booth products into an ACC_W-bit accumulator and
// hands each batch sum downstream over a valid/ready handshake. Upstream stalls
// while a finished sum is waiting to be taken.
// Build option: BOOTH_ACC_SAT_EN makes every addition saturate instead of wrap.
module booth_product_accum
    import booth_pkg::*;
#(
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum_data,
    input  logic              sum_ready,
    output logic              sum_ovf,
    output logic [7:0]        batch_cnt
);

    localparam logic [7:0] LastCnt = 8'(COUNT - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             sum_ovf_q, sum_ovf_d;
    logic             sticky_q, sticky_d;

    logic [31:0]      prod_ext;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             last;
    logic             take;

    // Product sign-extended to accumulator width.
    always_comb begin
        prod_ext = sext_prod(prod_data);
        add_b    = prod_ext[ACC_W-1:0];
    end

    logic unused_prod_ext;
    assign unused_prod_ext = ^prod_ext;

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Handshake qualifiers; prod_ready never looks at prod_valid.
    always_comb begin
        prod_ready = (state_q == StAccum) && !clear;
        accept     = prod_valid && prod_ready;
        last       = (cnt_q == LastCnt);
        // In StHold sum_valid is always set, so sum_ready alone completes the transfer.
        take       = (state_q == StHold) && sum_ready;
    end

    // Next state: close the batch on the last product, reopen once the sum is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: begin
                if (accept && last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (sum_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
        if (clear) begin
            state_d = StAccum;
        end
    end

    // Next accumulator, count, overflow sticky and output-sum values.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        sum_ovf_d   = sum_ovf_q;

        if (clear) begin
            // Pending sum is dropped but sum_data keeps its last value.
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            sum_valid_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                sum_d       = add_sum;
                sum_ovf_d   = sticky_q | add_ovf;
                sum_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                sticky_d    = 1'b0;
            end else begin
                acc_d    = add_sum;
                cnt_d    = cnt_q + 8'd1;
                sticky_d = sticky_q | add_ovf;
            end
        end else if (take) begin
            sum_valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            sum_ovf_q   <= sum_ovf_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        sum_valid = sum_valid_q;
        sum_data  = sum_q;
        sum_ovf   = sum_ovf_q;
        batch_cnt = cnt_q;
    end

endmodule

// File: tb/tb_booth_product_accum.sv
// Bench for booth_product_accum: three instances (COUNT/ACC_W = 4/12, 4/8, 1/12)
// checked against an integer-arithmetic batch model.
module tb_booth_product_accum;

    logic clk = 1'b0;
    logic rst, clear;
    always #5 clk = ~clk;

    // Instance A: COUNT=4, ACC_W=12
    logic a_pv, a_pr, a_sv, a_sr, a_so;
    logic [7:0] a_pd, a_bc;
    logic [11:0] a_sd;
    // Instance B: COUNT=4, ACC_W=8
    logic b_pv, b_pr, b_sv, b_sr, b_so;
    logic [7:0] b_pd, b_bc;
    logic [7:0] b_sd;
    // Instance C: COUNT=1, ACC_W=12
    logic c_pv, c_pr, c_sv, c_sr, c_so;
    logic [7:0] c_pd, c_bc;
    logic [11:0] c_sd;

    int total = 0;
    int bad = 0;

    booth_product_accum #(.COUNT(4), .ACC_W(12)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .prod_valid(a_pv), .prod_data(a_pd),
        .prod_ready(a_pr), .sum_valid(a_sv), .sum_data(a_sd), .sum_ready(a_sr),
        .sum_ovf(a_so), .batch_cnt(a_bc));

    booth_product_accum #(.COUNT(4), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .prod_valid(b_pv), .prod_data(b_pd),
        .prod_ready(b_pr), .sum_valid(b_sv), .sum_data(b_sd), .sum_ready(b_sr),
        .sum_ovf(b_so), .batch_cnt(b_bc));

    booth_product_accum #(.COUNT(1), .ACC_W(12)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .prod_valid(c_pv), .prod_data(c_pd),
        .prod_ready(c_pr), .sum_valid(c_sv), .sum_data(c_sd), .sum_ready(c_sr),
        .sum_ovf(c_so), .batch_cnt(c_bc));

    // Reference: true integer sum per step, then wrap or clamp on leaving the range.
    function automatic void ref_batch(input int acc_w, input logic [7:0] p[$],
                                      output logic [31:0] sum, output logic ovf);
        longint lim;
        longint acc;
        longint t;
        lim = longint'(1) << (acc_w - 1);
        acc = 0;
        ovf = 1'b0;
        foreach (p[i]) begin
            t = acc + longint'($signed(p[i]));
            if (t >= lim || t < -lim) begin
                ovf = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
                acc = (t >= lim) ? lim - 1 : -lim;
`else
                acc = (t >= lim) ? t - 2 * lim : t + 2 * lim;
`endif
            end else begin
                acc = t;
            end
        end
        sum = 32'(acc);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [7:0] p);
        a_pv = 1'b1;
        a_pd = p;
        #1;
        total++;
        if (a_pr !== 1'b1) begin bad++; $display("FAIL feed_a_ready: got %b want 1", a_pr); end
        step();
        a_pv = 1'b0;
    endtask

    task automatic feed_b(input logic [7:0] p);
        b_pv = 1'b1;
        b_pd = p;
        #1;
        total++;
        if (b_pr !== 1'b1) begin bad++; $display("FAIL feed_b_ready: got %b want 1", b_pr); end
        step();
        b_pv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0;
        a_pv = 0; a_pd = 0; a_sr = 0;
        b_pv = 0; b_pd = 0; b_sr = 0;
        c_pv = 0; c_pd = 0; c_sr = 0;
        step(); step();
        rst = 1'b0;
        #1;
        total += 7;
        if (a_pr !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", a_pr); end
        if (a_sv !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", a_sv); end
        if (a_sd !== 12'h0) begin bad++; $display("FAIL rst_data: got %h want 000", a_sd); end
        if (a_so !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", a_so); end
        if (a_bc !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", a_bc); end
        if (b_sd !== 8'h0) begin bad++; $display("FAIL rst_b_data: got %h want 00", b_sd); end
        if (c_sv !== 1'b0) begin bad++; $display("FAIL rst_c_valid: got %b want 0", c_sv); end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [31:0] es;
        logic eo;
        q = '{8'h06, 8'hF4, 8'h31, 8'h01};
        ref_batch(12, q, es, eo);
        foreach (q[i]) begin
            feed_a(q[i]);
            if (i < 3) begin
                total++;
                if (a_bc !== 8'(i + 1)) begin
                    bad++; $display("FAIL basic_cnt: got %0d want %0d", a_bc, i + 1);
                end
            end
        end
        total += 6;
        if (a_sv !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", a_sv); end
        if (a_sd !== es[11:0]) begin bad++; $display("FAIL basic_data: got %h want %h", a_sd, es[11:0]); end
        if (a_sd !== 12'h02C) begin bad++; $display("FAIL basic_data44: got %h want 02c", a_sd); end
        if (a_so !== eo) begin bad++; $display("FAIL basic_ovf: got %b want %b", a_so, eo); end
        if (a_pr !== 1'b0) begin bad++; $display("FAIL basic_ready: got %b want 0", a_pr); end
        if (a_bc !== 8'd0) begin bad++; $display("FAIL basic_cnt_end: got %0d want 0", a_bc); end
    endtask

    task automatic test_backpressure();
        a_pv = 1'b1; a_pd = 8'h55; a_sr = 1'b0;
        repeat (5) begin
            step();
            total += 4;
            if (a_sv !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", a_sv); end
            if (a_sd !== 12'h02C) begin bad++; $display("FAIL bp_data: got %h want 02c", a_sd); end
            if (a_bc !== 8'd0) begin bad++; $display("FAIL bp_cnt: got %0d want 0", a_bc); end
            if (a_pr !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", a_pr); end
        end
        a_pv = 1'b0; a_sr = 1'b1;
        step();
        a_sr = 1'b0;
        total += 3;
        if (a_sv !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", a_sv); end
        if (a_pr !== 1'b1) begin bad++; $display("FAIL bp_reopen: got %b want 1", a_pr); end
        if (a_bc !== 8'd0) begin bad++; $display("FAIL bp_cnt_after: got %0d want 0", a_bc); end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [31:0] es;
        logic eo;
        q = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        ref_batch(8, q, es, eo);
        foreach (q[i]) feed_b(q[i]);
        total += 4;
        if (b_sv !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", b_sv); end
        if (b_sd !== es[7:0]) begin bad++; $display("FAIL ovf_data: got %h want %h", b_sd, es[7:0]); end
`ifdef BOOTH_ACC_SAT_EN
        if (b_sd !== 8'h7F) begin bad++; $display("FAIL ovf_data_sat: got %h want 7f", b_sd); end
`else
        if (b_sd !== 8'hFC) begin bad++; $display("FAIL ovf_data_wrap: got %h want fc", b_sd); end
`endif
        if (b_so !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", b_so); end
        b_sr = 1'b1; step(); b_sr = 1'b0;
    endtask

    task automatic test_clear();
        feed_a(8'h10);
        feed_a(8'h20);
        total++;
        if (a_bc !== 8'd2) begin bad++; $display("FAIL clr_cnt_pre: got %0d want 2", a_bc); end
        a_pv = 1'b1; a_pd = 8'h40; clear = 1'b1;
        #1;
        total++;
        if (a_pr !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", a_pr); end
        step();
        clear = 1'b0; a_pv = 1'b0;
        total += 2;
        if (a_bc !== 8'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", a_bc); end
        if (a_sv !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", a_sv); end
        repeat (4) feed_a(8'h01);
        total += 3;
        if (a_sv !== 1'b1) begin bad++; $display("FAIL clr_sum_valid: got %b want 1", a_sv); end
        if (a_sd !== 12'h004) begin bad++; $display("FAIL clr_sum: got %h want 004", a_sd); end
        if (a_so !== 1'b0) begin bad++; $display("FAIL clr_sum_ovf: got %b want 0", a_so); end
        a_sr = 1'b1; step(); a_sr = 1'b0;
    endtask

    task automatic test_hold_clear_reset();
        logic [7:0] q[$];
        logic [31:0] es;
        logic eo;
        q = {};
        repeat (4) q.push_back(8'($urandom));
        ref_batch(12, q, es, eo);
        foreach (q[i]) feed_a(q[i]);
        total += 2;
        if (a_sv !== 1'b1) begin bad++; $display("FAIL hc_valid: got %b want 1", a_sv); end
        if (a_sd !== es[11:0]) begin bad++; $display("FAIL hc_data: got %h want %h", a_sd, es[11:0]); end
        clear = 1'b1; a_sr = 1'b1;
        step();
        clear = 1'b0; a_sr = 1'b0;
        #1;
        total += 3;
        if (a_sv !== 1'b0) begin bad++; $display("FAIL hc_drop: got %b want 0", a_sv); end
        if (a_pr !== 1'b1) begin bad++; $display("FAIL hc_ready: got %b want 1", a_pr); end
        if (a_sd !== es[11:0]) begin bad++; $display("FAIL hc_keep: got %h want %h", a_sd, es[11:0]); end
        // Fill another batch, then reset in HOLD.
        repeat (4) feed_a(8'h7F);
        rst = 1'b1; step(); rst = 1'b0;
        total += 5;
        if (a_sv !== 1'b0) begin bad++; $display("FAIL hr_valid: got %b want 0", a_sv); end
        if (a_sd !== 12'h0) begin bad++; $display("FAIL hr_data: got %h want 000", a_sd); end
        if (a_so !== 1'b0) begin bad++; $display("FAIL hr_ovf: got %b want 0", a_so); end
        if (a_bc !== 8'd0) begin bad++; $display("FAIL hr_cnt: got %0d want 0", a_bc); end
        if (a_pr !== 1'b1) begin bad++; $display("FAIL hr_ready: got %b want 1", a_pr); end
        // Reset mid-batch must discard the partial sum.
        feed_a(8'h33); feed_a(8'h44);
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if (a_bc !== 8'd0) begin bad++; $display("FAIL hr_mid_cnt: got %0d want 0", a_bc); end
        q = '{8'h02, 8'hFF, 8'h03, 8'h05};
        ref_batch(12, q, es, eo);
        foreach (q[i]) feed_a(q[i]);
        total++;
        if (a_sd !== es[11:0]) begin bad++; $display("FAIL hr_mid_sum: got %h want %h", a_sd, es[11:0]); end
        a_sr = 1'b1; step(); a_sr = 1'b0;
    endtask

    task automatic test_count1();
        c_pv = 1'b1; c_pd = 8'h80;
        #1;
        total++;
        if (c_pr !== 1'b1) begin bad++; $display("FAIL c1_ready_pre: got %b want 1", c_pr); end
        step();
        c_pv = 1'b0;
        total += 5;
        if (c_sv !== 1'b1) begin bad++; $display("FAIL c1_valid: got %b want 1", c_sv); end
        if (c_sd !== 12'hF80) begin bad++; $display("FAIL c1_data: got %h want f80", c_sd); end
        if (c_so !== 1'b0) begin bad++; $display("FAIL c1_ovf: got %b want 0", c_so); end
        if (c_pr !== 1'b0) begin bad++; $display("FAIL c1_ready: got %b want 0", c_pr); end
        if (c_bc !== 8'd0) begin bad++; $display("FAIL c1_cnt: got %0d want 0", c_bc); end
        c_sr = 1'b1; step(); c_sr = 1'b0;
        total++;
        if (c_sv !== 1'b0) begin bad++; $display("FAIL c1_drop: got %b want 0", c_sv); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [31:0] es;
        logic eo;
        for (int b = 0; b < 8; b++) begin
            q = {};
            repeat (4) q.push_back(8'($urandom));
            ref_batch(12, q, es, eo);
            foreach (q[i]) begin
                repeat ($urandom_range(0, 2)) begin
                    a_pd = 8'($urandom);
                    step();
                end
                feed_a(q[i]);
                if (i < 3) begin
                    total++;
                    if (a_sv !== 1'b0) begin bad++; $display("FAIL rnd_early_valid: got %b want 0", a_sv); end
                end
            end
            total += 3;
            if (a_sv !== 1'b1) begin bad++; $display("FAIL rnd_valid: got %b want 1", a_sv); end
            if (a_sd !== es[11:0]) begin bad++; $display("FAIL rnd_data: got %h want %h", a_sd, es[11:0]); end
            if (a_so !== eo) begin bad++; $display("FAIL rnd_ovf: got %b want %b", a_so, eo); end
            a_pv = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                a_pd = 8'($urandom);
                step();
                total += 2;
                if (a_sd !== es[11:0]) begin bad++; $display("FAIL rnd_hold: got %h want %h", a_sd, es[11:0]); end
                if (a_bc !== 8'd0) begin bad++; $display("FAIL rnd_hold_cnt: got %0d want 0", a_bc); end
            end
            a_pv = 1'b0; a_sr = 1'b1; step(); a_sr = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            q = {};
            repeat (4) q.push_back(8'($urandom));
            ref_batch(8, q, es, eo);
            foreach (q[i]) feed_b(q[i]);
            total += 2;
            if (b_sd !== es[7:0]) begin bad++; $display("FAIL rnd_b_data: got %h want %h", b_sd, es[7:0]); end
            if (b_so !== eo) begin bad++; $display("FAIL rnd_b_ovf: got %b want %b", b_so, eo); end
            b_sr = 1'b1; step(); b_sr = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_clear();
        test_hold_clear_reset();
        test_count1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
